sram_req_ctrl: RTL and testbench

//  Initiator side of the single-port synchronous SRAM macro interface (active-low nce/nwe, byte write mask).

---
 rtl/sram_ctrl_pkg.sv | 21 ++
 rtl/sram_resp_fifo.sv | 53 +++++
 rtl/sram_req_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sram_req_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared constants and helpers for the SRAM request controller
package sram_ctrl_pkg;

   localparam int READ_LAT = 3;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   // Cycles spent in FLUSH after the last flush request
   localparam logic [1:0] FLUSH_CYCLES = 2'd3;

   function automatic logic [7:0] count_ones(input logic [READ_LAT-1:0] v);
      logic [7:0] n;
      n = '0;
      for (int i = 0; i < READ_LAT; i++) begin
         n = n + {7'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// rtl/sram_resp_fifo.sv - first-word-fall-through response FIFO with sync clear and occupancy count
module sram_resp_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_push = i_push && (r_count != CW'(DEPTH));
   assign w_do_pop  = i_pop && (r_count != '0);

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rptr];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/sram_req_ctrl.sv
// rtl/sram_req_ctrl.sv - single-port SRAM initiator with read tracking and in-order response buffering
// Optional request/stall counters are built when SRAM_REQ_CTRL_STATS_EN is defined.
module sram_req_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int WORD_SIZE  = 32,
   parameter int NUM_WORDS  = 1024,
   parameter int TAG_W      = 4,
   parameter int RESP_DEPTH = 4,
   localparam int AW = $clog2(NUM_WORDS),
   localparam int BW = WORD_SIZE / 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 IN_flush,
   input  logic                 IN_req_valid,
   output logic                 OUT_req_ready,
   input  logic                 IN_req_we,
   input  logic [AW-1:0]        IN_req_addr,
   input  logic [WORD_SIZE-1:0] IN_req_data,
   input  logic [BW-1:0]        IN_req_wm,
   input  logic [TAG_W-1:0]     IN_req_tag,
   output logic                 OUT_resp_valid,
   input  logic                 IN_resp_ready,
   output logic [WORD_SIZE-1:0] OUT_resp_data,
   output logic [TAG_W-1:0]     OUT_resp_tag,
   output logic                 OUT_mem_nce,
   output logic                 OUT_mem_nwe,
   output logic [AW-1:0]        OUT_mem_addr,
   output logic [WORD_SIZE-1:0] OUT_mem_data,
   output logic [BW-1:0]        OUT_mem_wm,
   input  logic [WORD_SIZE-1:0] IN_mem_rdata,
   output logic                 OUT_busy
`ifdef SRAM_REQ_CTRL_STATS_EN
   ,
   output logic [31:0]          OUT_stat_reads,
   output logic [31:0]          OUT_stat_writes,
   output logic [31:0]          OUT_stat_stalls
`endif
);

   localparam int CW = $clog2(RESP_DEPTH + 1);
   localparam int SW = CW + 1;

   typedef struct packed {
      logic [WORD_SIZE-1:0] data;
      logic [TAG_W-1:0]     tag;
   } resp_t;

   logic [0:0]           r_state;
   logic [1:0]           r_flush_cnt;
   logic [READ_LAT-1:0]  r_pipe_vld;
   logic [TAG_W-1:0]     r_pipe_tag [READ_LAT];
   logic                 r_mem_nce;
   logic                 r_mem_nwe;
   logic [AW-1:0]        r_mem_addr;
   logic [WORD_SIZE-1:0] r_mem_data;
   logic [BW-1:0]        r_mem_wm;

   logic                 w_req_ready;
   logic                 w_accept;
   logic [SW-1:0]        w_inflight;
   logic                 w_push;
   logic                 w_pop;
   resp_t                w_push_data;
   resp_t                w_head;
   logic                 w_fifo_empty;
   logic [CW-1:0]        w_fifo_count;

   // Credits cover every read from accept until pop, so the FIFO cannot overflow
   always_comb begin
      w_inflight  = SW'(count_ones(r_pipe_vld)) + SW'(w_fifo_count);
      w_req_ready = (r_state == ST_RUN) && !IN_flush && (w_inflight < SW'(RESP_DEPTH));
   end

   assign w_accept = IN_req_valid && w_req_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_nce  <= 1'b1;
         r_mem_nwe  <= 1'b1;
         r_mem_addr <= '0;
         r_mem_data <= '0;
         r_mem_wm   <= '0;
      end else if (w_accept) begin
         r_mem_nce  <= 1'b0;
         r_mem_nwe  <= !IN_req_we;
         r_mem_addr <= IN_req_addr;
         r_mem_data <= IN_req_data;
         r_mem_wm   <= IN_req_wm;
      end else begin
         r_mem_nce  <= 1'b1;
         r_mem_nwe  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || IN_flush) begin
         r_pipe_vld <= '0;
      end else begin
         r_pipe_vld <= {r_pipe_vld[READ_LAT-2:0], w_accept && !IN_req_we};
      end
   end

   always_ff @(posedge clk) begin
      r_pipe_tag[0] <= IN_req_tag;
      for (int i = 1; i < READ_LAT; i++) begin
         r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_flush_cnt <= '0;
      end else if (IN_flush) begin
         r_state     <= ST_FLUSH;
         r_flush_cnt <= FLUSH_CYCLES;
      end else if (r_state == ST_FLUSH) begin
         r_flush_cnt <= r_flush_cnt - 2'd1;
         if (r_flush_cnt == 2'd1) r_state <= ST_RUN;
      end
   end

   assign w_push           = r_pipe_vld[READ_LAT-1];
   assign w_push_data.data = IN_mem_rdata;
   assign w_push_data.tag  = r_pipe_tag[READ_LAT-1];
   assign w_pop            = !w_fifo_empty && IN_resp_ready;

   sram_resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .WIDTH (WORD_SIZE + TAG_W)
   ) u_resp_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_clear (IN_flush),
      .i_push  (w_push),
      .i_wdata (w_push_data),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   assign OUT_req_ready  = w_req_ready;
   assign OUT_resp_valid = !w_fifo_empty;
   assign OUT_resp_data  = w_head.data;
   assign OUT_resp_tag   = w_head.tag;
   assign OUT_mem_nce    = r_mem_nce;
   assign OUT_mem_nwe    = r_mem_nwe;
   assign OUT_mem_addr   = r_mem_addr;
   assign OUT_mem_data   = r_mem_data;
   assign OUT_mem_wm     = r_mem_wm;
   assign OUT_busy       = (|r_pipe_vld) || !w_fifo_empty || (r_state == ST_FLUSH);

`ifdef SRAM_REQ_CTRL_STATS_EN
   logic [31:0] r_stat_reads;
   logic [31:0] r_stat_writes;
   logic [31:0] r_stat_stalls;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_reads  <= '0;
         r_stat_writes <= '0;
         r_stat_stalls <= '0;
      end else begin
         if (w_accept && !IN_req_we)       r_stat_reads  <= r_stat_reads + 32'd1;
         if (w_accept && IN_req_we)        r_stat_writes <= r_stat_writes + 32'd1;
         if (IN_req_valid && !w_req_ready) r_stat_stalls <= r_stat_stalls + 32'd1;
      end
   end

   assign OUT_stat_reads  = r_stat_reads;
   assign OUT_stat_writes = r_stat_writes;
   assign OUT_stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb/tb_sram_req_ctrl.sv - directed self-checking bench for sram_req_ctrl with a 2-cycle SRAM model
module tb_sram_req_ctrl;

   localparam int WS = 32;
   localparam int AW = 10;
   localparam int TW = 4;
   localparam int BW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [WS-1:0] req_data;
   logic [BW-1:0] req_wm;
   logic [TW-1:0] req_tag;
   logic          resp_valid;
   logic          resp_ready;
   logic [WS-1:0] resp_data;
   logic [TW-1:0] resp_tag;
   logic          mem_nce;
   logic          mem_nwe;
   logic [AW-1:0] mem_addr;
   logic [WS-1:0] mem_data;
   logic [BW-1:0] mem_wm;
   logic [WS-1:0] mem_rdata;
   logic          busy;
`ifdef SRAM_REQ_CTRL_STATS_EN
   logic [31:0]   stat_reads;
   logic [31:0]   stat_writes;
   logic [31:0]   stat_stalls;
   int            stall_cnt = 0;
`endif
   logic          count_stalls = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sram_req_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .IN_flush       (flush),
      .IN_req_valid   (req_valid),
      .OUT_req_ready  (req_ready),
      .IN_req_we      (req_we),
      .IN_req_addr    (req_addr),
      .IN_req_data    (req_data),
      .IN_req_wm      (req_wm),
      .IN_req_tag     (req_tag),
      .OUT_resp_valid (resp_valid),
      .IN_resp_ready  (resp_ready),
      .OUT_resp_data  (resp_data),
      .OUT_resp_tag   (resp_tag),
      .OUT_mem_nce    (mem_nce),
      .OUT_mem_nwe    (mem_nwe),
      .OUT_mem_addr   (mem_addr),
      .OUT_mem_data   (mem_data),
      .OUT_mem_wm     (mem_wm),
      .IN_mem_rdata   (mem_rdata),
      .OUT_busy       (busy)
`ifdef SRAM_REQ_CTRL_STATS_EN
      ,
      .OUT_stat_reads  (stat_reads),
      .OUT_stat_writes (stat_writes),
      .OUT_stat_stalls (stat_stalls)
`endif
   );

   // SRAM: pins registered one edge after the controller drives them, data out one edge later
   logic [WS-1:0] mem [16];
   logic [WS-1:0] sram_q1;
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
      end else if (!mem_nce && !mem_nwe) begin
         for (int b = 0; b < BW; b++)
            if (mem_wm[b]) mem[mem_addr[3:0]][b*8 +: 8] <= mem_data[b*8 +: 8];
      end
      if (!mem_nce && mem_nwe) sram_q1 <= mem[mem_addr[3:0]];
      mem_rdata <= sram_q1;
   end

`ifdef SRAM_REQ_CTRL_STATS_EN
   always @(negedge clk) if (count_stalls && req_valid && !req_ready) stall_cnt++;
`endif

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [WS-1:0] d,
                         input logic [BW-1:0] m, input logic [TW-1:0] t);
      bit ok = 1'b0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_data  = d;
      req_wm    = m;
      req_tag   = t;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         if (req_ready) ok = 1'b1;
      end
      check("req_accept", {63'd0, ok}, 64'd1);
      step();
      req_valid = 1'b0;
   endtask

   task automatic get_resp(input logic [TW-1:0] t, input logic [WS-1:0] d);
      bit ok = 1'b0;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         if (resp_valid) ok = 1'b1;
      end
      check("resp_seen", {63'd0, ok}, 64'd1);
      check("resp_tag", {60'd0, resp_tag}, {60'd0, t});
      check("resp_data", {32'd0, resp_data}, {32'd0, d});
      step();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_data = '0; req_wm = '0; req_tag = '0; resp_ready = 1'b1;

      // reset state
      step(); step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_nce", {63'd0, mem_nce}, 64'd1);
      check("rst_nwe", {63'd0, mem_nwe}, 64'd1);
      check("rst_addr", {54'd0, mem_addr}, 64'd0);
      check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("rst_ready", {63'd0, req_ready}, 64'd1);
      check("rst_busy", {63'd0, busy}, 64'd0);
      step();

      // full-word write then read, latency 3 edges after accept
      do_req(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, 4'd0);
      @(negedge clk);
      check("wr_nce", {63'd0, mem_nce}, 64'd0);
      check("wr_nwe", {63'd0, mem_nwe}, 64'd0);
      check("wr_addr", {54'd0, mem_addr}, 64'd5);
      check("wr_data", {32'd0, mem_data}, 64'hDEADBEEF);
      check("wr_wm", {60'd0, mem_wm}, 64'hF);
      step();
      do_req(1'b0, 10'd5, 32'd0, 4'h0, 4'd3);
      @(negedge clk);
      check("rd_nce", {63'd0, mem_nce}, 64'd0);
      check("rd_nwe", {63'd0, mem_nwe}, 64'd1);
      check("lat_c1", {63'd0, resp_valid}, 64'd0);
      step(); @(negedge clk);
      check("idle_nce", {63'd0, mem_nce}, 64'd1);
      check("lat_c2", {63'd0, resp_valid}, 64'd0);
      step(); @(negedge clk);
      check("lat_c3", {63'd0, resp_valid}, 64'd0);
      step(); @(negedge clk);
      check("lat_c4", {63'd0, resp_valid}, 64'd1);
      check("t2_data", {32'd0, resp_data}, 64'hDEADBEEF);
      check("t2_tag", {60'd0, resp_tag}, 64'd3);
      step(); @(negedge clk);
      check("t2_popped", {63'd0, resp_valid}, 64'd0);
      check("t2_idle", {63'd0, busy}, 64'd0);
      step();

      // byte-masked write followed back-to-back by a read of the same word
      do_req(1'b1, 10'd5, 32'h11223344, 4'b0101, 4'd0);
      do_req(1'b0, 10'd5, 32'd0, 4'h0, 4'd7);
      get_resp(4'd7, 32'hDE22BE44);

      // credit limit with response port stalled, then in-order drain
      rst = 1'b1; step(); step(); rst = 1'b0;
      resp_ready   = 1'b0;
      count_stalls = 1'b1;
      for (int i = 0; i < 4; i++) do_req(1'b0, 10'(i), 32'd0, 4'h0, 4'(i));
      @(negedge clk);
      check("t4_ready_drop", {63'd0, req_ready}, 64'd0);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd4; req_tag = 4'd4;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t4_ready_held", {63'd0, req_ready}, 64'd0);
      end
      step();
      resp_ready = 1'b1;
      fork
         begin
            for (int i = 4; i < 8; i++) do_req(1'b0, 10'(i), 32'd0, 4'h0, 4'(i));
         end
         begin
            for (int i = 0; i < 8; i++) get_resp(4'(i), 32'hC0DE_0000 + 32'(i));
         end
      join
      count_stalls = 1'b0;
`ifdef SRAM_REQ_CTRL_STATS_EN
      check("stat_reads", {32'd0, stat_reads}, 64'd8);
      check("stat_writes", {32'd0, stat_writes}, 64'd0);
      check("stat_stalls", {32'd0, stat_stalls}, 64'(stall_cnt));
`endif

      // flush with two reads in flight; a request in the flush cycle is not taken
      do_req(1'b0, 10'd1, 32'd0, 4'h0, 4'd1);
      do_req(1'b0, 10'd2, 32'd0, 4'h0, 4'd2);
      flush = 1'b1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd4; req_tag = 4'd5;
      @(negedge clk);
      check("fl_ready_now", {63'd0, req_ready}, 64'd0);
      step();
      flush = 1'b0;
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("fl_ready", {63'd0, req_ready}, 64'd0);
         check("fl_busy", {63'd0, busy}, 64'd1);
         check("fl_no_resp", {63'd0, resp_valid}, 64'd0);
         step();
      end
      @(negedge clk);
      check("fl_ready_back", {63'd0, req_ready}, 64'd1);
      check("fl_busy_clear", {63'd0, busy}, 64'd0);
      for (int i = 0; i < 5; i++) begin
         step(); @(negedge clk);
         check("fl_stale", {63'd0, resp_valid}, 64'd0);
      end
      step();

      // reset while a read is in flight drops it
      do_req(1'b0, 10'd3, 32'd0, 4'h0, 4'd9);
      rst = 1'b1; step(); step(); rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("rst_drop", {63'd0, resp_valid}, 64'd0);
         step();
      end
      @(negedge clk);
      check("rst_drop_busy", {63'd0, busy}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
